// File: rtl/pipe_shadow_tracker.sv
// Shadow copy of an N-stage in-order pipeline: replays fetch, stall and flush
// against its own state and flags every stage where the core's reported state diverges.
module pipe_shadow_tracker #(
  parameter int unsigned     STAGES   = 6,
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] PC_INIT  = 32'h200,
  parameter logic [ILEN-1:0] NOP_INSN = 32'h13,
  parameter logic [XLEN-1:0] PC_MASK  = 32'hffff_fffc,
  parameter int unsigned     CNT_W    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid_i,
  input  logic [XLEN-1:0]        if_pc_i,
  input  logic [ILEN-1:0]        if_insn_i,
  input  logic [STAGES-1:0]      stall_i,
  input  logic [STAGES-1:0]      flush_i,
  input  logic [STAGES-1:0]      dut_bubble_i,
  input  logic [STAGES*XLEN-1:0] dut_pc_i,
  input  logic [STAGES*ILEN-1:0] dut_insn_i,
  input  logic                   chk_en_i,
  output logic [STAGES-1:0]      shd_bubble_o,
  output logic [STAGES*XLEN-1:0] shd_pc_o,
  output logic [STAGES*ILEN-1:0] shd_insn_o,
  output logic [STAGES-1:0]      mismatch_o,
  output logic                   err_o,
  output logic [3:0]             err_stage_o,
  output logic [CNT_W-1:0]       retire_cnt_o
);

  logic [XLEN-1:0]   pc_q   [STAGES];
  logic [ILEN-1:0]   insn_q [STAGES];
  logic [XLEN-1:0]   pc_d   [STAGES];
  logic [ILEN-1:0]   insn_d [STAGES];
  logic [STAGES-1:0] bubble_q, bubble_d;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] diff, gated;
  logic [3:0]        low_idx;
  logic              first_q;
  logic              retire_en;

  // A stall anywhere downstream freezes every stage above it.
  always_comb begin
    hold[STAGES-1] = stall_i[STAGES-1];
    for (int k = STAGES-2; k >= 0; k--) begin
      hold[k] = stall_i[k] | hold[k+1];
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_d     = pc_q;
    insn_d   = insn_q;
    bubble_d = bubble_q;
    if (hold[0]) begin
      bubble_d[0] = bubble_q[0] | flush_i[0];
    end else begin
      pc_d[0]     = if_pc_i & PC_MASK;
      insn_d[0]   = if_insn_i;
      bubble_d[0] = ~if_valid_i;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (hold[k]) begin
        bubble_d[k] = bubble_q[k] | flush_i[k];
      end else begin
        // Payload always advances; a held upstream stage hands down a bubble.
        pc_d[k]     = pc_q[k-1];
        insn_d[k]   = insn_q[k-1];
        bubble_d[k] = hold[k-1] ? 1'b1 : (bubble_q[k-1] | flush_i[k-1]);
      end
    end
  end

  always_comb begin
    diff = '0;
    for (int k = 0; k < STAGES; k++) begin
      diff[k] = (bubble_q[k] != dut_bubble_i[k]) |
                (~bubble_q[k] & ~dut_bubble_i[k] &
                 ((pc_q[k]   != dut_pc_i[k*XLEN +: XLEN]) |
                  (insn_q[k] != dut_insn_i[k*ILEN +: ILEN])));
    end
    gated = diff & {STAGES{chk_en_i & ~first_q}};
  end

  always_comb begin
    low_idx = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      if (gated[k]) low_idx = 4'(k);
    end
  end

  assign retire_en = ~bubble_q[STAGES-1] & ~hold[STAGES-1] & ~flush_i[STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // The stage arrays are a handful of flops, not a RAM, so they reset like any register.
      for (int k = 0; k < STAGES; k++) begin
        pc_q[k]   <= PC_INIT;
        insn_q[k] <= NOP_INSN;
      end
      bubble_q     <= '1;
      first_q      <= 1'b1;
      mismatch_o   <= '0;
      err_o        <= 1'b0;
      err_stage_o  <= '0;
      retire_cnt_o <= '0;
    end else begin
      pc_q       <= pc_d;
      insn_q     <= insn_d;
      bubble_q   <= bubble_d;
      first_q    <= 1'b0;
      mismatch_o <= gated;
      if (!err_o && (gated != '0)) begin
        err_o       <= 1'b1;
        err_stage_o <= low_idx;
      end
      if (retire_en && (retire_cnt_o != '1)) begin
        retire_cnt_o <= retire_cnt_o + CNT_W'(1);
      end
    end
  end

  assign shd_bubble_o = bubble_q;

  for (genvar g = 0; g < STAGES; g++) begin : g_pack
    assign shd_pc_o[g*XLEN +: XLEN]   = pc_q[g];
    assign shd_insn_o[g*ILEN +: ILEN] = insn_q[g];
  end

endmodule

// File: tb/tb_pipe_shadow_tracker.sv
// Directed bench for pipe_shadow_tracker: a table of per-cycle vectors with hand-computed
// bubble/mismatch/error/retire values, plus hand sequences for flush, reset and saturation.
module tb_pipe_shadow_tracker;
  localparam int S = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             if_valid = 1'b0;
  logic [31:0]      if_pc = '0;
  logic [31:0]      if_insn = '0;
  logic [S-1:0]     stall = '0;
  logic [S-1:0]     flush = '0;
  logic [S-1:0]     dut_bubble = '1;
  logic [S*32-1:0]  dut_pc = '0;
  logic [S*32-1:0]  dut_insn = '0;
  logic             chk_en = 1'b0;
  logic [S-1:0]     shd_bubble;
  logic [S*32-1:0]  shd_pc;
  logic [S*32-1:0]  shd_insn;
  logic [S-1:0]     mismatch;
  logic             err;
  logic [3:0]       err_stage;
  logic [63:0]      retire_cnt;

  // Small instance used only to reach counter saturation and the two-stage minimum.
  logic [1:0]       s_bubble;
  logic [63:0]      s_pc;
  logic [63:0]      s_insn;
  logic [1:0]       s_mismatch;
  logic             s_err;
  logic [3:0]       s_err_stage;
  logic [2:0]       s_retire;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc   [S];
  logic [31:0] m_insn [S];
  logic [S-1:0] m_bub;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [S-1:0] st, fl;
    logic        chk;
    logic [S-1:0] cpc, cins, cbub;
    logic [S-1:0] bub, mis;
    logic        err;
    logic [3:0]  est;
    int          ret;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_shadow_tracker #(.STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_pc_i(if_pc), .if_insn_i(if_insn),
    .stall_i(stall), .flush_i(flush), .dut_bubble_i(dut_bubble), .dut_pc_i(dut_pc),
    .dut_insn_i(dut_insn), .chk_en_i(chk_en), .shd_bubble_o(shd_bubble), .shd_pc_o(shd_pc),
    .shd_insn_o(shd_insn), .mismatch_o(mismatch), .err_o(err), .err_stage_o(err_stage),
    .retire_cnt_o(retire_cnt)
  );

  pipe_shadow_tracker #(.STAGES(2), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .if_valid_i(1'b1), .if_pc_i(32'h0), .if_insn_i(32'h0),
    .stall_i(2'b00), .flush_i(2'b00), .dut_bubble_i(2'b11), .dut_pc_i(64'h0),
    .dut_insn_i(64'h0), .chk_en_i(1'b0), .shd_bubble_o(s_bubble), .shd_pc_o(s_pc),
    .shd_insn_o(s_insn), .mismatch_o(s_mismatch), .err_o(s_err), .err_stage_o(s_err_stage),
    .retire_cnt_o(s_retire)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [31:0] pc);
    return {pc[19:0], 12'h013};
  endfunction

  // Reference pipeline: walk stages from the tail so each reads its predecessor's old value.
  task automatic model_step(input logic r, input logic v, input logic [31:0] pc,
                            input logic [31:0] insn, input logic [S-1:0] st, input logic [S-1:0] fl);
    logic [S-1:0] h;
    h[S-1] = st[S-1];
    for (int k = S-2; k >= 0; k--) h[k] = st[k] | h[k+1];
    if (r) begin
      for (int k = 0; k < S; k++) begin
        m_pc[k]   = 32'h200;
        m_insn[k] = 32'h13;
      end
      m_bub = '1;
    end else begin
      for (int k = S-1; k >= 1; k--) begin
        if (h[k]) begin
          m_bub[k] = m_bub[k] | fl[k];
        end else begin
          m_pc[k]   = m_pc[k-1];
          m_insn[k] = m_insn[k-1];
          m_bub[k]  = h[k-1] | m_bub[k-1] | fl[k-1];
        end
      end
      if (h[0]) begin
        m_bub[0] = m_bub[0] | fl[0];
      end else begin
        m_pc[0]   = pc & 32'hffff_fffc;
        m_insn[0] = insn;
        m_bub[0]  = ~v;
      end
    end
  endtask

  // One clock: drive at negedge with core-side state mirroring the reference (plus any
  // injected corruption), then compare shadow PC/insn against the reference after the edge.
  task automatic step(input logic r, input logic v, input logic [31:0] pc,
                      input logic [S-1:0] st, input logic [S-1:0] fl, input logic chk,
                      input logic [S-1:0] cpc, input logic [S-1:0] cins, input logic [S-1:0] cbub);
    @(negedge clk);
    rst      = r;
    if_valid = v;
    if_pc    = pc | 32'h3;
    if_insn  = mk_insn(pc);
    stall    = st;
    flush    = fl;
    chk_en   = chk;
    for (int k = 0; k < S; k++) begin
      dut_pc[k*32 +: 32]   = m_pc[k] ^ (cpc[k] ? 32'h10 : 32'h0);
      dut_insn[k*32 +: 32] = m_insn[k] ^ (cins[k] ? 32'h20 : 32'h0);
      dut_bubble[k]        = m_bub[k] ^ cbub[k];
    end
    @(posedge clk);
    model_step(r, v, pc | 32'h3, mk_insn(pc), st, fl);
    #1;
    for (int k = 0; k < S; k++) begin
      check($sformatf("shd_pc[%0d]", k), 64'(shd_pc[k*32 +: 32]), 64'(m_pc[k]));
      check($sformatf("shd_insn[%0d]", k), 64'(shd_insn[k*32 +: 32]), 64'(m_insn[k]));
    end
  endtask

  task automatic add(input logic v, input logic [31:0] pc, input logic [S-1:0] st, input logic [S-1:0] fl,
                     input logic chk, input logic [S-1:0] cpc, input logic [S-1:0] cins,
                     input logic [S-1:0] cbub, input logic [S-1:0] bub, input logic [S-1:0] mis,
                     input logic e, input logic [3:0] est, input int ret);
    vec_t t;
    t.v = v; t.pc = pc; t.st = st; t.fl = fl; t.chk = chk;
    t.cpc = cpc; t.cins = cins; t.cbub = cbub;
    t.bub = bub; t.mis = mis; t.err = e; t.est = est; t.ret = ret;
    tbl.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < S; k++) begin
      m_pc[k]   = 32'h200;
      m_insn[k] = 32'h13;
    end
    m_bub = '1;

    //   v  pc        stall      flush      chk cpc        cins       cbub       bubble     mismatch   err est ret
    add(1, 32'h200, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b111110, 6'b000000, 0, 0, 0);
    add(1, 32'h204, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b111100, 6'b000000, 0, 0, 0);
    add(1, 32'h208, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b111000, 6'b000000, 0, 0, 0);
    add(1, 32'h20c, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b110000, 6'b000000, 0, 0, 0);
    add(1, 32'h210, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b100000, 6'b000000, 0, 0, 0);
    add(1, 32'h214, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 0, 0, 0);
    add(1, 32'h218, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 0, 0, 1);
    add(1, 32'h21c, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 0, 0, 2);
    add(1, 32'h220, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 0, 0, 3);
    add(1, 32'h224, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 0, 0, 4);
    add(1, 32'h228, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 0, 0, 5);
    // stage-2 stall for three cycles; a pc-only difference on a double bubble is ignored
    add(1, 32'h22c, 6'b000100, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b000000, 0, 0, 6);
    add(1, 32'h22c, 6'b000100, 6'b000000, 1, 6'b001000, 6'b000000, 6'b000000, 6'b011000, 6'b000000, 0, 0, 7);
    add(1, 32'h22c, 6'b000100, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b111000, 6'b000000, 0, 0, 8);
    add(1, 32'h22c, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b110000, 6'b000000, 0, 0, 8);
    add(1, 32'h230, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b100000, 6'b000000, 0, 0, 8);
    add(1, 32'h234, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 0, 0, 8);
    // flush stages 0-1: 0x234 and 0x230 become bubbles and never retire
    add(1, 32'h238, 6'b000000, 6'b000011, 1, 6'b000000, 6'b000000, 6'b000000, 6'b000110, 6'b000000, 0, 0, 9);
    add(1, 32'h23c, 6'b000000, 6'b000000, 1, 6'b000110, 6'b000110, 6'b000000, 6'b001100, 6'b000000, 0, 0, 10);
    // checking disabled while corruptions are injected
    add(1, 32'h240, 6'b000000, 6'b000000, 0, 6'b100000, 6'b000001, 6'b000000, 6'b011000, 6'b000000, 0, 0, 11);
    add(1, 32'h244, 6'b000000, 6'b000000, 0, 6'b000000, 6'b000000, 6'b000100, 6'b110000, 6'b000000, 0, 0, 12);
    // stage-3 insn corrupted, then a later stage-1 mismatch leaves the captured stage alone
    add(1, 32'h248, 6'b000000, 6'b000000, 1, 6'b000000, 6'b001000, 6'b000000, 6'b100000, 6'b001000, 1, 3, 12);
    add(1, 32'h24c, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 1, 3, 12);
    add(1, 32'h250, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000010, 6'b000000, 6'b000000, 6'b000010, 1, 3, 13);
    add(1, 32'h254, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 6'b100000, 6'b000000, 6'b100000, 1, 3, 14);
    add(1, 32'h258, 6'b000000, 6'b000000, 1, 6'b000100, 6'b000000, 6'b000000, 6'b000000, 6'b000100, 1, 3, 15);

    step(1, 0, 32'h0, '0, '0, 0, '0, '0, '0);
    step(1, 0, 32'h0, '0, '0, 0, '0, '0, '0);
    check("reset_bubble", 64'(shd_bubble), 64'h3f);
    check("reset_pc5", 64'(shd_pc[5*32 +: 32]), 64'h200);
    check("reset_insn0", 64'(shd_insn[31:0]), 64'h13);
    check("reset_mismatch", 64'(mismatch), 64'h0);
    check("reset_err", 64'(err), 64'h0);
    check("reset_err_stage", 64'(err_stage), 64'h0);
    check("reset_retire", retire_cnt, 64'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].v, tbl[i].pc, tbl[i].st, tbl[i].fl, tbl[i].chk,
           tbl[i].cpc, tbl[i].cins, tbl[i].cbub);
      check($sformatf("v%0d_bubble", i+1), 64'(shd_bubble), 64'(tbl[i].bub));
      check($sformatf("v%0d_mismatch", i+1), 64'(mismatch), 64'(tbl[i].mis));
      check($sformatf("v%0d_err", i+1), 64'(err), 64'(tbl[i].err));
      check($sformatf("v%0d_err_stage", i+1), 64'(err_stage), 64'(tbl[i].est));
      check($sformatf("v%0d_retire", i+1), retire_cnt, 64'(tbl[i].ret));
      if (i == 5) check("pc200_at_stage5", 64'(shd_pc[5*32 +: 32]), 64'h200);
    end
    check("sat_retire", 64'(s_retire), 64'h7);

    // flush and stall together on stage 2: it turns bubble but keeps its PC
    step(0, 1, 32'h25c, 6'b000100, 6'b000100, 1, '0, '0, '0);
    check("fs_bubble", 64'(shd_bubble), 64'h0c);
    check("fs_pc2", 64'(shd_pc[2*32 +: 32]), 64'h250);
    check("fs_pc3", 64'(shd_pc[3*32 +: 32]), 64'h250);
    check("fs_retire", retire_cnt, 64'd16);

    // flush on the last stage blocks retirement of 0x248
    step(0, 1, 32'h25c, 6'b000000, 6'b100000, 1, '0, '0, '0);
    check("lastflush_retire", retire_cnt, 64'd16);
    check("lastflush_bubble", 64'(shd_bubble), 64'h18);
    step(0, 1, 32'h260, 6'b000000, 6'b000000, 1, '0, '0, 6'b000001);
    check("resume_retire", retire_cnt, 64'd17);
    check("pre_rst_mismatch", 64'(mismatch), 64'h01);
    check("pre_rst_err_stage", 64'(err_stage), 64'h3);

    // mid-stream reset with the sticky error set
    step(1, 1, 32'h264, 6'b000000, 6'b000000, 1, '0, '0, 6'b000001);
    check("mrst_bubble", 64'(shd_bubble), 64'h3f);
    check("mrst_pc0", 64'(shd_pc[31:0]), 64'h200);
    check("mrst_retire", retire_cnt, 64'h0);
    check("mrst_err", 64'(err), 64'h0);
    check("mrst_err_stage", 64'(err_stage), 64'h0);
    check("mrst_mismatch", 64'(mismatch), 64'h0);
    check("mrst_sat_retire", 64'(s_retire), 64'h0);

    // first cycle after release: an injected mismatch is suppressed
    step(0, 0, 32'h300, '0, '0, 1, '0, '0, 6'b000100);
    check("first_mismatch", 64'(mismatch), 64'h0);
    check("first_err", 64'(err), 64'h0);
    check("first_bubble", 64'(shd_bubble), 64'h3f);

    // two simultaneous mismatches: the lowest stage is captured
    step(0, 1, 32'h300, '0, '0, 1, '0, '0, 6'b010010);
    check("multi_mismatch", 64'(mismatch), 64'h12);
    check("multi_err", 64'(err), 64'h1);
    check("multi_err_stage", 64'(err_stage), 64'h1);
    check("multi_bubble", 64'(shd_bubble), 64'h3e);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
